// File: rtl/ps2_keyboard_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx_fifo
//
// Receives PS/2 keyboard frames and queues the scancodes in a show-ahead
// FIFO. The receiver does not queue E0 and F0 prefix bytes. Instead it folds
// them into per-entry is_ext / is_break flags.
//
// Ports
//   clk        system clock
//   clrn       synchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   rd_en      pop the FIFO head (ignored when empty)
//   err_clr    clear the sticky overflow / frame_err flags
//   code       scancode at the FIFO head (0 when empty)
//   is_ext     head entry was preceded by E0
//   is_break   head entry was preceded by F0
//   valid      FIFO not empty
//   count      number of entries held, 0..FIFO_DEPTH
//   overflow   sticky: an entry was dropped because the FIFO was full
//   frame_err  sticky: bad start/parity/stop, or a frame timed out
// ---------------------------------------------------------------------------
module ps2_keyboard_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    code,
    output logic                          is_ext,
    output logic                          is_break,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ------------------------------------------------------------------
    // Synchronisers. A third ps2_clk flop gives the falling-edge detect.
    // The flops reset to 1, which is the idle bus level, so reset release
    // cannot produce a false edge.
    // ------------------------------------------------------------------
    logic ps2_clk_s1, ps2_clk_s2, ps2_clk_s3;
    logic ps2_data_s1, ps2_data_s2;
    logic fall;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ps2_clk_s1  <= 1'b1;
            ps2_clk_s2  <= 1'b1;
            ps2_clk_s3  <= 1'b1;
            ps2_data_s1 <= 1'b1;
            ps2_data_s2 <= 1'b1;
        end else begin
            ps2_clk_s1  <= ps2_clk;
            ps2_clk_s2  <= ps2_clk_s1;
            ps2_clk_s3  <= ps2_clk_s2;
            ps2_data_s1 <= ps2_data;
            ps2_data_s2 <= ps2_data_s1;
        end
    end

    assign fall = ps2_clk_s3 & ~ps2_clk_s2;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state, state_nx;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    logic          start_en, shift_en, parity_en, stop_sample;
    logic          frame_ok, frame_bad;

    assign timeout_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

    // State register
    always_ff @(posedge clk) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic. The timeout takes priority over any edge.
    // NOTE: the default assignment at the top of every always_comb keeps
    // all paths assigned, so no latch is inferred.
    always_comb begin
        state_nx = state;
        if (timeout_hit) begin
            state_nx = IDLE;
        end else if (fall) begin
            unique case (state)
                IDLE:    if (!ps2_data_s2) state_nx = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output logic: per-cycle strobes that drive the datapath
    always_comb begin
        start_en    = 1'b0;
        shift_en    = 1'b0;
        parity_en   = 1'b0;
        stop_sample = 1'b0;
        if (fall && !timeout_hit) begin
            start_en    = (state == IDLE) && !ps2_data_s2;
            shift_en    = (state == DATA);
            parity_en   = (state == PARITY);
            stop_sample = (state == STOP);
        end
        // Odd parity: the XOR of the data bits and the parity bit must be 1
        frame_ok  = stop_sample && ps2_data_s2 && (^{shift_reg, parity_bit});
        frame_bad = (stop_sample && !frame_ok) || timeout_hit;
    end

    // Receive datapath
    logic       rx_done;
    logic [7:0] rx_byte;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
            rx_done    <= 1'b0;
            rx_byte    <= '0;
        end else begin
            if (start_en) bit_cnt <= '0;
            if (shift_en) begin
                shift_reg <= {ps2_data_s2, shift_reg[7:1]};  // LSB first
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (parity_en) parity_bit <= ps2_data_s2;

            if (state == IDLE || fall)       to_cnt <= '0;
            else if (!timeout_hit)           to_cnt <= to_cnt + 1'b1;

            // An accepted byte is registered here and pushed one cycle later
            rx_done <= frame_ok;
            if (frame_ok) rx_byte <= shift_reg;
        end
    end

    // ------------------------------------------------------------------
    // Prefix handling
    // ------------------------------------------------------------------
    logic ext_pending, brk_pending;
    logic is_prefix;
    logic push_req;

    assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
    assign push_req  = rx_done && !is_prefix;

    // Flags clear on every push request, including one dropped on overflow
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
        end else if (rx_done) begin
            if (rx_byte == 8'hE0) begin
                ext_pending <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk_pending <= 1'b1;
            end else begin
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, do_pop, do_push, drop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign do_pop  = rd_en && valid;
    // A push into a full FIFO still succeeds when a pop frees a slot this cycle
    assign do_push = push_req && (!full || do_pop);
    assign drop    = push_req && full && !do_pop;

    // NOTE: the storage array is deliberately not reset; the outputs are
    // gated by valid, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {ext_pending, brk_pending, rx_byte};
    end

    // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH by themselves
    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign {is_ext, is_break, code} = valid ? mem[rd_ptr] : 10'd0;

    // ------------------------------------------------------------------
    // Sticky error flags. A new error wins over err_clr in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clrn) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop)         overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;

            if (frame_bad)    frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for ps2_keyboard_rx_fifo. Directed PS/2 frames with
// hand-computed expected results. TIMEOUT_CYCLES is shortened to 200 so the
// timeout case stays quick. The PS/2 bit period is 16 clk cycles.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_rx_fifo;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;
    logic       valid;
    logic [3:0] count;
    logic       overflow;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    ps2_keyboard_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .code      (code),
        .is_ext    (is_ext),
        .is_break  (is_break),
        .valid     (valid),
        .count     (count),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send the first nbits of a frame: start, 8 data bits LSB first, parity, stop.
    // mode 1: check that valid rises exactly one cycle after the push cycle.
    // mode 2: assert rd_en for the single cycle in which the byte is pushed.
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input int nbits, input int mode);
        logic [10:0] frame;
        frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                repeat (3) @(negedge clk);
                check("lat_pre", valid, 1'b0);
                @(negedge clk);
                check("lat_post", valid, 1'b1);
                repeat (4) @(negedge clk);
            end else if (i == 10 && mode == 2) begin
                repeat (3) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_err_clr;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_head", {is_ext, is_break, code}, 0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // Single 1C frame, with push latency checked inside the task
        send_frame(8'h1C, 1'b0, 11, 1);
        check("1c_count", count, 1);
        check("1c_head", {is_ext, is_break, code}, {2'b00, 8'h1C});
        pop();
        check("1c_popped", valid, 0);
        pop();  // rd_en while empty is ignored
        check("empty_pop", count, 0);

        // E0 F0 75 collapses into one entry
        send_frame(8'hE0, 1'b0, 11, 0);
        send_frame(8'hF0, 1'b0, 11, 0);
        send_frame(8'h75, 1'b0, 11, 0);
        check("e0f0_count", count, 1);
        check("e0f0_head", {is_ext, is_break, code}, {2'b11, 8'h75});
        pop();

        // E0 74 gives an extended make; the flags were cleared by the last push
        send_frame(8'hE0, 1'b0, 11, 0);
        send_frame(8'h74, 1'b0, 11, 0);
        check("e0_head", {is_ext, is_break, code}, {2'b10, 8'h74});
        pop();

        // Bad parity
        send_frame(8'h1C, 1'b1, 11, 0);
        check("par_count", count, 0);
        check("par_ferr", frame_err, 1);
        pulse_err_clr();
        check("par_clr", frame_err, 0);
        send_frame(8'h1C, 1'b0, 11, 0);
        check("par_next", {count, code}, {4'd1, 8'h1C});
        pop();

        // Timeout after start plus four data bits
        send_frame(8'h32, 1'b0, 5, 0);
        repeat (TIMEOUT + 20) @(negedge clk);
        check("to_ferr", frame_err, 1);
        check("to_count", count, 0);
        pulse_err_clr();
        send_frame(8'h32, 1'b0, 11, 0);
        check("to_next", {count, is_ext, is_break, code}, {4'd1, 2'b00, 8'h32});
        check("to_ferr_clr", frame_err, 0);
        pop();

        // Overflow: nine pushes into a depth-8 FIFO
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 11, 0);
        check("ovf_count", count, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_head", code, 8'h01);
        pulse_err_clr();
        check("ovf_clr", overflow, 0);
        // Push coinciding with a pop while full
        send_frame(8'h0A, 1'b0, 11, 2);
        check("fullrw_count", count, DEPTH);
        check("fullrw_ovf", overflow, 0);
        for (int k = 2; k <= 8; k++) begin
            check($sformatf("drain_%0d", k), code, 8'(k));
            pop();
        end
        check("drain_last", code, 8'h0A);
        pop();
        check("drain_empty", count, 0);

        // Reset mid-frame, with an entry held, an error set and E0 pending
        send_frame(8'h11, 1'b0, 11, 0);
        send_frame(8'h11, 1'b1, 11, 0);
        send_frame(8'hE0, 1'b0, 11, 0);
        check("pre_rst", {count, frame_err}, {4'd1, 1'b1});
        send_frame(8'h55, 1'b0, 6, 0);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        check("mid_rst_count", count, 0);
        check("mid_rst_flags", {valid, overflow, frame_err}, 3'b000);
        check("mid_rst_head", {is_ext, is_break, code}, 0);
        send_frame(8'h1C, 1'b0, 11, 0);
        check("post_rst", {count, is_ext, is_break, code}, {4'd1, 2'b00, 8'h1C});
        check("post_rst_ferr", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
